song_player: RTL and testbench

Autoplay sequencer for the electronic-organ design. It reads encoded note words from a synchronous song ROM and hands each note to the shared sound engine over a start/over handshake. It drives the note LEDs for the note currently sounding. It is the playback counterpart of free-play mode, where notes come from the keys: here the song memory generates the notes and the sound engine consumes them.

---
 rtl/song_player.sv | 147 ++++++++++++++
 tb/tb_song_player.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_player.sv
// rtl/song_player.sv - autoplay song sequencer feeding the sound engine; optional SONG_LOOP_EN replays the song
module song_player #(
  parameter int OCT_W      = 2,
  parameter int NOTE_W     = 3,
  parameter int LEN_W      = 3,
  parameter int ADDR_W     = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            play,
  input  logic                            pause,
  output logic [ADDR_W-1:0]               rd_addr,
  input  logic [OCT_W+NOTE_W+LEN_W-1:0]   rd_data,
  output logic                            snd_start,
  output logic [OCT_W-1:0]                snd_octave,
  output logic [NOTE_W-1:0]               snd_note,
  output logic [LEN_W-1:0]                snd_length,
  input  logic                            snd_over,
  output logic [6:0]                      led,
  output logic                            playing,
  output logic                            done
);

  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_PLAY,
    S_GAP,
    S_PAUSED
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   gap_cnt, cnt_next;
  logic [ADDR_W-1:0]  addr_next;
  logic               pause_req, pause_req_next;
  logic               end_hit;
  logic               done_arm;
  logic [6:0]         led_next;

  // Next state, next address, gap counter and pause request
  always_comb begin
    state_next     = state;
    addr_next      = rd_addr;
    cnt_next       = gap_cnt;
    end_hit        = 1'b0;
    pause_req_next = pause_req;

    case (state)
      S_IDLE:   if (play) state_next = S_FETCH;
      S_FETCH:  state_next = S_LOAD;
      S_LOAD: begin
        if (rd_data == '0) end_hit = 1'b1;
        else               state_next = S_ISSUE;
      end
      S_ISSUE:  state_next = S_PLAY;
      S_PLAY: begin
        if (snd_over) begin
          state_next = S_GAP;
          cnt_next   = CNT_W'(GAP_CYCLES - 1);
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          if (rd_addr == '1) begin
            end_hit = 1'b1;
          end else begin
            addr_next  = rd_addr + 1'b1;
            state_next = pause_req ? S_PAUSED : S_FETCH;
          end
        end else begin
          cnt_next = gap_cnt - 1'b1;
        end
      end
      S_PAUSED: if (pause) state_next = S_FETCH;
      default:  state_next = S_IDLE;
    endcase

    // End marker or address wrap
    if (end_hit) begin
`ifdef SONG_LOOP_EN
      addr_next  = '0;
      state_next = S_FETCH;
`else
      state_next = S_IDLE;
`endif
    end

    if (!en) state_next = S_IDLE;
    if (state_next == S_IDLE) addr_next = '0;

    // Pause request toggles outside IDLE; the resume pulse in PAUSED clears it
    if (state == S_IDLE || state_next == S_IDLE) pause_req_next = 1'b0;
    else if (state == S_PAUSED && pause)         pause_req_next = 1'b0;
    else if (pause)                              pause_req_next = ~pause_req;

    // One-hot LED for the note that sounds from the next cycle; rest lights nothing
    led_next = '0;
    if (state_next == S_PLAY) begin
      for (int i = 0; i < 7; i++) begin
        if (snd_note == NOTE_W'(i + 1)) led_next[i] = 1'b1;
      end
    end
  end

  // Control state, address, gap counter and pause request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rd_addr   <= '0;
      gap_cnt   <= '0;
      pause_req <= 1'b0;
    end else begin
      state     <= state_next;
      rd_addr   <= addr_next;
      gap_cnt   <= cnt_next;
      pause_req <= pause_req_next;
    end
  end

  // Registered outputs; done lags the end decision by one cycle so it lands in the slot a start pulse would use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snd_start  <= 1'b0;
      snd_octave <= '0;
      snd_note   <= '0;
      snd_length <= '0;
      led        <= '0;
      playing    <= 1'b0;
      done_arm   <= 1'b0;
      done       <= 1'b0;
    end else begin
      snd_start <= (state == S_ISSUE) && (state_next == S_PLAY);
      if (state == S_LOAD && en) {snd_octave, snd_note, snd_length} <= rd_data;
      led      <= led_next;
      playing  <= (state_next != S_IDLE) && (state_next != S_PAUSED);
      done_arm <= end_hit && en;
      done     <= done_arm;
    end
  end

endmodule

// File: tb/tb_song_player.sv
// tb/tb_song_player.sv - directed table-driven bench for song_player
module tb_song_player;
  localparam int GAP  = 16;
  localparam int GAP2 = 3;

  logic       clk = 1'b0;
  logic       rst_n, en, play, pause, snd_over;
  logic [7:0] rd_addr, rd_data;
  logic       snd_start, playing, done;
  logic [1:0] snd_octave;
  logic [2:0] snd_note, snd_length;
  logic [6:0] led;

  logic       en2, play2, pause2, over2;
  logic [1:0] rd_addr2;
  logic [7:0] rd_data2;
  logic       snd_start2, playing2, done2;
  logic [1:0] snd_octave2;
  logic [2:0] snd_note2, snd_length2;
  logic [6:0] led2;

  logic [7:0] rom  [256];
  logic [7:0] rom2 [4];

  int vectors = 0;
  int miscompares = 0;

  song_player #(.ADDR_W(8), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .play(play), .pause(pause),
    .rd_addr(rd_addr), .rd_data(rd_data), .snd_start(snd_start),
    .snd_octave(snd_octave), .snd_note(snd_note), .snd_length(snd_length),
    .snd_over(snd_over), .led(led), .playing(playing), .done(done)
  );

  song_player #(.ADDR_W(2), .GAP_CYCLES(GAP2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .play(play2), .pause(pause2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .snd_start(snd_start2),
    .snd_octave(snd_octave2), .snd_note(snd_note2), .snd_length(snd_length2),
    .snd_over(over2), .led(led2), .playing(playing2), .done(done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data  <= rom[rd_addr];
  always @(posedge clk) rd_data2 <= rom2[rd_addr2];

  typedef struct {
    logic [7:0] word;
    int         over_wait;
    logic [6:0] exp_led;
    int         exp_oct;
    int         exp_note;
    int         exp_len;
    bit         stray;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig_of(input int w);
    case (w)
      0:       return snd_start;
      1:       return done;
      2:       return !playing;
      3:       return snd_start2;
      4:       return done2;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (sig_of(which)) break;
    end
  endtask

  task automatic pulse_over();
    snd_over = 1'b1;
    tick();
    snd_over = 1'b0;
  endtask

  initial begin
    int n, maxa, cnt;

    vecs[0] = '{8'h9C, 2, 7'b0000100, 2, 3, 4, 1'b0};
    vecs[1] = '{8'h42, 5, 7'b0000000, 1, 0, 2, 1'b0};
    vecs[2] = '{8'hFF, 1, 7'b1000000, 3, 7, 7, 1'b1};
    vecs[3] = '{8'h09, 3, 7'b0000001, 0, 1, 1, 1'b0};

    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom2[0] = 8'h9C; rom2[1] = 8'h42; rom2[2] = 8'hFF; rom2[3] = 8'h09;

    en = 1'b1; play = 1'b0; pause = 1'b0; snd_over = 1'b0;
    en2 = 1'b1; play2 = 1'b0; pause2 = 1'b0; over2 = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_addr", int'(rd_addr), 0);
    check("rst_start", int'(snd_start), 0);
    check("rst_fields", int'({snd_octave, snd_note, snd_length}), 0);
    check("rst_led", int'(led), 0);
    check("rst_playing", int'(playing), 0);
    check("rst_done", int'(done), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single-note songs from the table
    for (int i = 0; i < 4; i++) begin
      rom[0] = vecs[i].word;
      rom[1] = 8'h00;
      play = 1'b1; tick(); play = 1'b0;
      wait_sig(0, 10, n);
      check("start_lat", n, 3);
      check("octave", int'(snd_octave), vecs[i].exp_oct);
      check("note", int'(snd_note), vecs[i].exp_note);
      check("length", int'(snd_length), vecs[i].exp_len);
      check("led_play", int'(led), int'(vecs[i].exp_led));
      check("playing", int'(playing), 1);
      tick();
      check("start_pulse", int'(snd_start), 0);
      for (int j = 1; j < vecs[i].over_wait; j++) tick();
      check("led_hold", int'(led), int'(vecs[i].exp_led));
      pulse_over();
      check("led_off", int'(led), 0);
      n = 0; maxa = 0;
      while (n < 40) begin
        tick();
        n++;
        snd_over = vecs[i].stray && (n == 4);
        if (int'(rd_addr) > maxa) maxa = int'(rd_addr);
        if (done) break;
      end
      snd_over = 1'b0;
      check("done_lat", n, GAP + 3);
      check("max_addr", maxa, 1);
      check("idle_playing", int'(playing), 0);
      tick();
      check("done_pulse", int'(done), 0);
    end

    // play held high restarts after song end
    rom[0] = 8'h09; rom[1] = 8'h00;
    play = 1'b1; tick();
    wait_sig(0, 10, n);
    check("held_start_lat", n, 3);
    tick(); pulse_over();
    wait_sig(1, 40, n);
    check("held_done_lat", n, GAP + 3);
    wait_sig(0, 10, n);
    check("restart_lat", n, 3);
    play = 1'b0;
    check("restart_note", int'(snd_note), 1);
    tick(); pulse_over();
    wait_sig(1, 40, n);
    check("restart_done_lat", n, GAP + 3);
    tick();

    // Pause mid-note, resume, coincident pause + snd_over
    rom[0] = 8'h9C; rom[1] = 8'h42; rom[2] = 8'h00;
    play = 1'b1; tick(); play = 1'b0;
    wait_sig(0, 10, n);
    check("p_start_lat", n, 3);
    for (int j = 0; j < 4; j++) tick();
    pause = 1'b1; tick(); pause = 1'b0;
    check("p_note_runs", int'(led), 4);
    tick(); tick();
    pulse_over();
    wait_sig(2, 40, n);
    check("pause_entry", n, GAP);
    check("paused_addr", int'(rd_addr), 1);
    check("paused_led", int'(led), 0);
    for (int j = 0; j < 5; j++) tick();
    check("paused_hold", int'(playing), 0);
    pause = 1'b1; tick(); pause = 1'b0;
    wait_sig(0, 10, n);
    check("resume_lat", n, 3);
    check("resume_oct", int'(snd_octave), 1);
    check("resume_note", int'(snd_note), 0);
    check("resume_len", int'(snd_length), 2);
    check("resume_led", int'(led), 0);
    tick();
    pause = 1'b1; snd_over = 1'b1; tick(); pause = 1'b0; snd_over = 1'b0;
    wait_sig(2, 40, n);
    check("coincident_pause", n, GAP);
    check("coincident_addr", int'(rd_addr), 2);
    pause = 1'b1; tick(); pause = 1'b0;
    wait_sig(1, 10, n);
    check("resume_end_done", n, 3);
    tick();

    // Abort during the second note
    rom[0] = 8'h09; rom[1] = 8'h9C; rom[2] = 8'h00;
    play = 1'b1; tick(); play = 1'b0;
    wait_sig(0, 10, n);
    tick(); pulse_over();
    wait_sig(0, 30, n);
    check("second_start_lat", n, GAP + 3);
    check("second_addr", int'(rd_addr), 1);
    tick(); tick();
    en = 1'b0; tick();
    check("abort_led", int'(led), 0);
    check("abort_addr", int'(rd_addr), 0);
    check("abort_playing", int'(playing), 0);
    en = 1'b1;
    tick(); tick();
    pulse_over();
    cnt = 0;
    for (int j = 0; j < 30; j++) begin
      tick();
      if (snd_start) cnt++;
    end
    check("abort_no_start", cnt, 0);

    // Asynchronous reset while in GAP
    rom[0] = 8'h9C; rom[1] = 8'h00;
    play = 1'b1; tick(); play = 1'b0;
    wait_sig(0, 10, n);
    tick(); pulse_over();
    for (int j = 0; j < 5; j++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_addr", int'(rd_addr), 0);
    check("arst_start", int'(snd_start), 0);
    check("arst_fields", int'({snd_octave, snd_note, snd_length}), 0);
    check("arst_led", int'(led), 0);
    check("arst_playing", int'(playing), 0);
    check("arst_done", int'(done), 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("arst_idle", int'(playing), 0);

    // Address wrap on the 2-bit instance
    play2 = 1'b1; tick(); play2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_sig(3, 20, n);
      check("wrap_start_lat", n, (i == 0) ? 3 : GAP2 + 3);
      check("wrap_note", int'(snd_note2), int'(rom2[i][5:3]));
      tick();
      over2 = 1'b1; tick(); over2 = 1'b0;
    end
    wait_sig(4, 20, n);
    check("wrap_done_lat", n, GAP2 + 1);
`ifdef SONG_LOOP_EN
    wait_sig(3, 20, n);
    check("loop_restart_lat", n, 2);
    check("loop_note", int'(snd_note2), int'(rom2[0][5:3]));
    en2 = 1'b0; tick(); en2 = 1'b1;
`else
    check("wrap_idle", int'(playing2), 0);
    check("wrap_addr", int'(rd_addr2), 0);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
